i2c_cmd_sequencer: RTL and testbench
====================================

I2C_CMD_SEQUENCER -- requirements
Module: i2c_cmd_sequencer

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h50: 7-bit slave address driven on i2c_dev_addr.
REQ-002 SHALL have parameter NUM_CMDS, default 8, range 1..16: number of table entries executed per sequence.
REQ-003 SHALL have parameter MAX_RETRY, default 3: retries per entry after a failed attempt.
REQ-004 SHALL have parameter GAP_CYCLES, default 250000: idle cycles after each successful write (EEPROM write cycle); 18-bit counter.
REQ-005 SHALL have parameter TIMEOUT, default 100000: cycles allowed waiting for i2c_ack[0]; 17-bit counter.
REQ-006 SHALL have port sys_clk_50m, input, 1 bit: the single clock.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1 bit: a high level while in IDLE begins a sequence.
REQ-009 SHALL have port i2c_dev_addr, output, 7 bits: slave address.
REQ-010 SHALL have port i2c_reg_addr, output, 8 bits: current register address.
REQ-011 SHALL have port i2c_reg_data, output, 8 bits: current write data.
REQ-012 SHALL have port i2c_config, output, 8 bits: bit0 is a one-cycle write request, bit1 is a one-cycle read request, bits7:2 are 0.
REQ-013 SHALL have port i2c_ack, input, 8 bits: bit0 is a one-cycle transaction-done pulse, bit1 is a NACK flag valid with bit0.
REQ-014 SHALL have port i2c_read_data, input, 8 bits: read result, valid with i2c_ack[0].
REQ-015 SHALL have ports busy (output, 1 bit), done (output, 1-cycle pulse), err (output, 1 bit, sticky) and err_cnt (output, 4 bits).

Function
REQ-016 SHALL hold an internal table; entry i SHALL have reg_addr = i and reg_data = i XOR 8'h5A.
REQ-017 SHALL implement the states IDLE, ISSUE, WAIT, CHECK, GAP and FIN.
REQ-018 IDLE: when start=1, SHALL clear index, retry count, err and err_cnt, then go to ISSUE; busy SHALL be 1 in every state except IDLE.
REQ-019 ISSUE: SHALL drive reg_addr and reg_data for the current index, pulse i2c_config[0] for exactly 1 cycle, then go to WAIT; the addresses and data SHALL stay stable until the next ISSUE.
REQ-020 WAIT: on i2c_ack[0]=1, SHALL go to CHECK and latch i2c_ack[1]; if TIMEOUT cycles pass without it, SHALL go to CHECK with a NACK recorded.
REQ-021 CHECK: on success, SHALL go to GAP; on NACK with retries below MAX_RETRY, SHALL increment the retry count and go to ISSUE.
REQ-022 CHECK: on NACK with retries exhausted, SHALL set err, increment err_cnt (saturating at 15), skip the entry and go to GAP.
REQ-023 GAP: SHALL count GAP_CYCLES cycles, then clear the retry count and advance the index; after the last entry (index = NUM_CMDS-1) SHALL go to FIN, otherwise to ISSUE.
REQ-024 FIN: SHALL pulse done for 1 cycle and return to IDLE; err and err_cnt SHALL hold until the next start.
REQ-025 SHALL ignore start while busy; an i2c_ack[0] pulse outside WAIT SHALL be ignored.
REQ-026 If i2c_ack[0] arrives in the same cycle the timeout expires, SHALL use the ack.

Reset
REQ-027 When rst_n=0, SHALL asynchronously return to IDLE with all of the following at 0: i2c_config, busy, done, err, err_cnt, index, counters, i2c_reg_addr and i2c_reg_data.
REQ-028 SHALL drive i2c_dev_addr = DEV_ADDR at all times.
REQ-029 Reset mid-transaction SHALL abort with no further request pulses; the next start SHALL begin again at entry 0.

Configuration
REQ-030 With macro SEQ_READBACK_EN defined, every successful write SHALL be followed, after GAP, by states RISSUE (pulse i2c_config[1] for 1 cycle), RWAIT (same timeout rule as WAIT) and COMPARE.
REQ-031 With SEQ_READBACK_EN defined, COMPARE SHALL treat NACK, timeout or i2c_read_data != table data as a failure, set err, increment err_cnt (saturating) and then advance the index; readback SHALL not be retried.
REQ-032 Without SEQ_READBACK_EN, no read request SHALL ever be issued, and i2c_read_data SHALL be unused.

Verification
REQ-033 Reset, then start with an always-ACK model -> 8 write pulses with reg_addr 0..7 and data 5A,5B,58,59,5E,5F,5C,5D; done pulses once; err=0.
REQ-034 NACK on the first 2 attempts of entry 3 -> 3 write pulses with reg_addr=3; err=0; 10 write pulses in total.
REQ-035 Permanent NACK on entry 5 -> 4 attempts at reg_addr=5; err=1; err_cnt=1; entries 6 and 7 still written.
REQ-036 No ack ever (TIMEOUT=1000) -> each attempt ends after 1000 cycles; err_cnt=8 at done.
REQ-037 Assert rst_n=0 during WAIT of entry 2 -> all outputs 0; a new start re-issues from reg_addr=0.
REQ-038 With SEQ_READBACK_EN, model returns 8'h00 for entry 4 -> 8 write and 8 read pulses; err=1; err_cnt=1.

Source files
------------

// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: replays a fixed register-write table through an I2C master with retry and timeout.
// Optional readback verification of every successful write is enabled by defining SEQ_READBACK_EN.
module i2c_cmd_sequencer #(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int NUM_CMDS = 8,
  parameter int MAX_RETRY = 3,
  parameter int GAP_CYCLES = 250000,
  parameter int TIMEOUT = 100000
) (
  input  logic       sys_clk_50m,
  input  logic       rst_n,
  input  logic       start,
  output logic [6:0] i2c_dev_addr,
  output logic [7:0] i2c_reg_addr,
  output logic [7:0] i2c_reg_data,
  output logic [7:0] i2c_config,
  input  logic [7:0] i2c_ack,
  input  logic [7:0] i2c_read_data,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] err_cnt
);
`ifdef SEQ_READBACK_EN
  localparam logic RB = 1'b1;
`else
  localparam logic RB = 1'b0;
`endif
  localparam logic [16:0] TO_LAST = 17'(TIMEOUT - 1);
  localparam logic [17:0] GAP_LAST = 18'(GAP_CYCLES - 1);
  localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);
  localparam logic [3:0] LAST_IDX = 4'(NUM_CMDS - 1);
  typedef enum logic [3:0] {IDLE, ISSUE, WAIT, CHECK, GAP, FIN, RISSUE, RWAIT, COMPARE} state_t;
  state_t state;
  logic [3:0] idx, retry;
  logic [17:0] gap_cnt;
  logic [16:0] to_cnt;
  logic nack, rb, wr_req, rd_req, last, unused_ack;
  assign last = idx == LAST_IDX;
  assign i2c_dev_addr = DEV_ADDR;
  assign i2c_config = {6'b0, rd_req, wr_req};
  assign unused_ack = ^i2c_ack[7:2];
  always_ff @(posedge sys_clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      retry <= '0;
      gap_cnt <= '0;
      to_cnt <= '0;
      nack <= 1'b0;
      rb <= 1'b0;
      wr_req <= 1'b0;
      rd_req <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      err_cnt <= '0;
      i2c_reg_addr <= '0;
      i2c_reg_data <= '0;
    end else begin
      wr_req <= 1'b0;
      rd_req <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          idx <= '0;
          retry <= '0;
          err <= 1'b0;
          err_cnt <= '0;
          busy <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: begin
          i2c_reg_addr <= {4'h0, idx};
          i2c_reg_data <= {4'h0, idx} ^ 8'h5a;
          wr_req <= 1'b1;
          state <= WAIT;
        end
        // an ack arriving on the expiry cycle wins over the timeout
        WAIT, RWAIT: if (i2c_ack[0] || to_cnt == TO_LAST) begin
          nack <= !i2c_ack[0] || i2c_ack[1] || (state == RWAIT && i2c_read_data != i2c_reg_data);
          to_cnt <= '0;
          state <= state == WAIT ? CHECK : COMPARE;
        end else to_cnt <= to_cnt + 17'd1;
        CHECK: begin
          rb <= RB && !nack;
          if (!nack) state <= GAP;
          else if (retry < RETRY_MAX) begin
            retry <= retry + 4'd1;
            state <= ISSUE;
          end else begin
            err <= 1'b1;
            if (err_cnt != 4'hf) err_cnt <= err_cnt + 4'd1;
            state <= GAP;
          end
        end
        GAP: if (gap_cnt == GAP_LAST) begin
          gap_cnt <= '0;
          if (rb) state <= RISSUE;
          else begin
            retry <= '0;
            idx <= idx + 4'd1;
            done <= last;
            state <= last ? FIN : ISSUE;
          end
        end else gap_cnt <= gap_cnt + 18'd1;
        RISSUE: begin
          rd_req <= 1'b1;
          state <= RWAIT;
        end
        COMPARE: begin
          if (nack) begin
            err <= 1'b1;
            if (err_cnt != 4'hf) err_cnt <= err_cnt + 4'd1;
          end
          retry <= '0;
          idx <= idx + 4'd1;
          done <= last;
          state <= last ? FIN : ISSUE;
        end
        FIN: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// tb_i2c_cmd_sequencer: directed checks of the command sequencer against a behavioural I2C master model.
module tb_i2c_cmd_sequencer;
`ifdef SEQ_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [6:0] i2c_dev_addr;
  logic [7:0] i2c_reg_addr, i2c_reg_data, i2c_config, i2c_ack, i2c_read_data;
  logic busy, done, err;
  logic [3:0] err_cnt;
  int checks = 0, errors = 0;
  int mode = 0, bad_rd = 0;
  int wr_total = 0, rd_total = 0, done_cnt = 0, cyc = 0;
  int wr_per [16];
  logic [7:0] wr_addr_log [32];
  logic [7:0] wr_data_log [32];
  int cyc_log [32];
  logic [7:0] exp_data [8] = '{8'h5a, 8'h5b, 8'h58, 8'h59, 8'h5e, 8'h5f, 8'h5c, 8'h5d};

  i2c_cmd_sequencer #(.NUM_CMDS(8), .MAX_RETRY(3), .GAP_CYCLES(5), .TIMEOUT(1000)) dut (
    .sys_clk_50m(clk), .rst_n(rst_n), .start(start), .i2c_dev_addr(i2c_dev_addr),
    .i2c_reg_addr(i2c_reg_addr), .i2c_reg_data(i2c_reg_data), .i2c_config(i2c_config),
    .i2c_ack(i2c_ack), .i2c_read_data(i2c_read_data), .busy(busy), .done(done),
    .err(err), .err_cnt(err_cnt));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic nk, input logic [7:0] d);
    repeat (2) @(posedge clk);
    #1 i2c_ack = {6'b0, nk, 1'b1};
    i2c_read_data = d;
    @(posedge clk);
    #1 i2c_ack = 8'h00;
  endtask

  initial begin
    i2c_ack = 8'h00;
    i2c_read_data = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (i2c_config[0]) begin
        logic [7:0] a;
        logic nk;
        a = i2c_reg_addr;
        if (wr_total < 32) begin
          wr_addr_log[wr_total] = a;
          wr_data_log[wr_total] = i2c_reg_data;
          cyc_log[wr_total] = cyc;
        end
        wr_total++;
        wr_per[a[3:0]]++;
        nk = (mode == 2 && a == 8'd5) || (mode == 1 && a == 8'd3 && wr_per[3] <= 2);
        if (mode != 3) send(nk, 8'h00);
      end else if (i2c_config[1]) begin
        rd_total++;
        send(1'b0, (bad_rd != 0 && i2c_reg_addr == 8'd4) ? 8'h00 : i2c_reg_data);
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    if (done) done_cnt++;
  end

  task automatic clear_logs();
    wr_total = 0;
    rd_total = 0;
    done_cnt = 0;
    for (int i = 0; i < 16; i++) wr_per[i] = 0;
  endtask

  task automatic run_seq(input int budget);
    int n;
    clear_logs();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 32'(n < budget), 32'd1);
    repeat (5) @(negedge clk);
    check("done_once", done_cnt, 1);
    check("busy_idle", busy, 1'b0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_err_cnt", err_cnt, 4'd0);
    check("rst_config", i2c_config, 8'h00);
    check("rst_reg_addr", i2c_reg_addr, 8'h00);
    check("rst_reg_data", i2c_reg_data, 8'h00);
    check("dev_addr", i2c_dev_addr, 7'h50);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    mode = 0;
    run_seq(2000);
    check("ack_wr_total", wr_total, 8);
    for (int i = 0; i < 8; i++) begin
      check("ack_addr", wr_addr_log[i], 8'(i));
      check("ack_data", wr_data_log[i], exp_data[i]);
    end
    check("ack_err", err, 1'b0);
    check("ack_err_cnt", err_cnt, 4'd0);
    check("ack_rd_total", rd_total, 8 * RB);

    mode = 1;
    run_seq(2000);
    check("retry_per3", wr_per[3], 3);
    check("retry_total", wr_total, 10);
    check("retry_err", err, 1'b0);

    mode = 2;
    run_seq(2000);
    check("perm_per5", wr_per[5], 4);
    check("perm_per6", wr_per[6], 1);
    check("perm_per7", wr_per[7], 1);
    check("perm_err", err, 1'b1);
    check("perm_err_cnt", err_cnt, 4'd1);
    check("perm_rd_total", rd_total, 7 * RB);

    mode = 3;
    run_seq(40000);
    check("to_total", wr_total, 32);
    check("to_spacing", cyc_log[1] - cyc_log[0], 1002);
    check("to_err", err, 1'b1);
    check("to_err_cnt", err_cnt, 4'd8);

    mode = 0;
    clear_logs();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    while (wr_total < 3 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("mid_reached", wr_total, 3);
    #2 rst_n = 1'b0;
    #1;
    check("mid_busy", busy, 1'b0);
    check("mid_config", i2c_config, 8'h00);
    check("mid_reg_addr", i2c_reg_addr, 8'h00);
    check("mid_reg_data", i2c_reg_data, 8'h00);
    check("mid_err_cnt", {err, done, err_cnt}, 6'd0);
    repeat (10) @(negedge clk);
    check("mid_no_pulse", wr_total, 3);
    rst_n = 1'b1;
    @(negedge clk);
    run_seq(2000);
    check("restart_addr0", wr_addr_log[0], 8'h00);
    check("restart_total", wr_total, 8);

`ifdef SEQ_READBACK_EN
    bad_rd = 1;
    run_seq(3000);
    check("rb_wr_total", wr_total, 8);
    check("rb_rd_total", rd_total, 8);
    check("rb_err", err, 1'b1);
    check("rb_err_cnt", err_cnt, 4'd1);
    bad_rd = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
